// File: rtl/pcs_pkg.sv
// pcs_pkg: sync header codes and block-lock state encoding shared by the PCS RX path.
package pcs_pkg;
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;
  typedef enum logic {ST_TEST, ST_SLIP_WAIT} lock_state_t;
endpackage

// File: rtl/block_lock_fsm.sv
// block_lock_fsm: 66b sync-header block lock, slipping the gearbox until 64 consecutive valid headers.
module block_lock_fsm
  import pcs_pkg::*;
#(
  parameter int HDR_WIDTH    = 2,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [HDR_WIDTH-1:0] i_sync_hdr,
  input  logic                 i_hdr_valid,
  output logic                 o_slip,
  output logic                 o_block_lock,
  output logic                 o_lock_lost,
  output logic [15:0]          o_slip_cnt
);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  lock_state_t state, state_n;
  logic [6:0]    sh_cnt, sh_cnt_n, sh_n;
  logic [4:0]    invld_cnt, invld_cnt_n, inv_n;
  logic [WW-1:0] wait_cnt, wait_cnt_n;
  logic          hdr_ok, ev, do_slip, win_end, wait_done;
  logic          slip_n, lock_n, lost_n;
  logic [15:0]   slip_cnt_n;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= ST_TEST;
      sh_cnt       <= '0;
      invld_cnt    <= '0;
      wait_cnt     <= '0;
      o_slip       <= 1'b0;
      o_block_lock <= 1'b0;
      o_lock_lost  <= 1'b0;
      o_slip_cnt   <= '0;
    end else begin
      state        <= state_n;
      sh_cnt       <= sh_cnt_n;
      invld_cnt    <= invld_cnt_n;
      wait_cnt     <= wait_cnt_n;
      o_slip       <= slip_n;
      o_block_lock <= lock_n;
      o_lock_lost  <= lost_n;
      o_slip_cnt   <= slip_cnt_n;
    end
  end

  // Slip outranks window end, so a 16th invalid landing on the 64th header still slips.
  always_comb begin
    hdr_ok    = (i_sync_hdr == SYNC_DATA) || (i_sync_hdr == SYNC_CTRL);
    ev        = i_hdr_valid && (state == ST_TEST);
    sh_n      = sh_cnt + 7'd1;
    inv_n     = invld_cnt + {4'd0, ~hdr_ok};
    do_slip   = ev && !hdr_ok && (!o_block_lock || inv_n == 5'(SH_INVLD_MAX));
    win_end   = ev && !do_slip && (sh_n == 7'(SH_CNT_MAX));
    wait_done = (state == ST_SLIP_WAIT) && (wait_cnt == '0);
    state_n   = do_slip ? ST_SLIP_WAIT : wait_done ? ST_TEST : state;
  end

  always_comb begin
    sh_cnt_n    = (do_slip || win_end) ? 7'd0 : ev ? sh_n : sh_cnt;
    invld_cnt_n = (do_slip || win_end) ? 5'd0 : ev ? inv_n : invld_cnt;
    wait_cnt_n  = do_slip ? WW'(SLIP_WAIT - 1) :
                  (state == ST_SLIP_WAIT && wait_cnt != '0) ? wait_cnt - 1'b1 : wait_cnt;
    slip_n      = do_slip;
    lost_n      = do_slip && o_block_lock;
    lock_n      = do_slip ? 1'b0 : (win_end && inv_n == 5'd0) ? 1'b1 : o_block_lock;
    slip_cnt_n  = (do_slip && o_slip_cnt != 16'hFFFF) ? o_slip_cnt + 16'd1 : o_slip_cnt;
  end
endmodule

// File: tb/tb_block_lock_fsm.sv
// tb_block_lock_fsm: directed header sequences against hand-computed lock/slip expectations.
module tb_block_lock_fsm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  hdr = 2'b00;
  logic        valid = 1'b0;
  logic        slip, lock, lost;
  logic [15:0] slip_cnt;
  int checks = 0;
  int failures = 0;

  block_lock_fsm dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_sync_hdr(hdr), .i_hdr_valid(valid),
    .o_slip(slip), .o_block_lock(lock), .o_lock_lost(lost), .o_slip_cnt(slip_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One header event followed by an idle gap cycle; returns at the negedge after the deciding edge.
  task automatic send(input logic [1:0] h);
    @(negedge clk);
    valid = 1'b1;
    hdr = h;
    @(negedge clk);
    valid = 1'b0;
    hdr = 2'b00;
  endtask

  function automatic logic [1:0] alt(input int i);
    return i[0] ? 2'b10 : 2'b01;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_slip", slip, 0);
    chk("rst_lock", lock, 0);
    chk("rst_lost", lost, 0);
    chk("rst_cnt", slip_cnt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send(alt(i));
      chk("t1_lock", lock, i == 63);
      chk("t1_slip", slip, 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t2_rst_lock", lock, 0);
    for (int i = 0; i < 9; i++) send(alt(i));
    chk("t2_pre_slip", slip, 0);
    send(2'b00);
    chk("t2_slip", slip, 1);
    chk("t2_cnt", slip_cnt, 1);
    chk("t2_lock", lock, 0);
    chk("t2_lost", lost, 0);
    for (int i = 0; i < 16; i++) begin
      send(2'b00);
      chk("t2_wait_slip", slip, 0);
    end
    chk("t2_wait_cnt", slip_cnt, 1);
    for (int i = 0; i < 64; i++) begin
      send(alt(i));
      chk("t2_relock", lock, i == 63);
    end
    for (int i = 0; i < 64; i++) begin
      send((i % 4 == 0 && i < 60) ? 2'b11 : alt(i));
      chk("t3_w15_lock", lock, 1);
      chk("t3_w15_slip", slip, 0);
    end
    for (int i = 0; i < 60; i++) begin
      send((i % 4 == 0) ? 2'b11 : alt(i));
      chk("t3_w16_pre", {slip, lock}, 2'b01);
    end
    send(2'b11);
    chk("t3_slip", slip, 1);
    chk("t3_lost", lost, 1);
    chk("t3_lock", lock, 0);
    chk("t3_cnt", slip_cnt, 2);
    @(negedge clk);
    chk("t3_slip_pulse", slip, 0);
    chk("t3_lost_pulse", lost, 0);
    repeat (32) @(negedge clk);
    for (int i = 0; i < 64; i++) send(alt(i));
    chk("t4_relock", lock, 1);
    for (int i = 0; i < 63; i++) send(alt(i));
    send(2'b11);
    chk("t4_last_inv_lock", lock, 1);
    chk("t4_last_inv_slip", slip, 0);
    chk("t4_last_inv_lost", lost, 0);
    for (int i = 0; i < 64; i++) begin
      send(alt(i));
      chk("t4_next_win", lock, 1);
    end
    for (int i = 0; i < 63; i++) send(i < 15 ? 2'b11 : alt(i));
    chk("t5_pre", {slip, lock}, 2'b01);
    send(2'b11);
    chk("t5_slip", slip, 1);
    chk("t5_lost", lost, 1);
    chk("t5_lock", lock, 0);
    chk("t5_cnt", slip_cnt, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_slip", slip, 0);
    chk("t6_lost", lost, 0);
    chk("t6_lock", lock, 0);
    chk("t6_cnt", slip_cnt, 0);
    send(2'b00);
    chk("t6_accept_slip", slip, 1);
    chk("t6_accept_cnt", slip_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
